// File: rtl/axis_out_packer_pkg.sv
// Shared types for the AXI-Stream output packer: element width modes and
// helpers that decode the raw mode field and give the per-element byte count.
package out_pkg;

    typedef enum logic [1:0] {
        OUT_8  = 2'd0,
        OUT_16 = 2'd1,
        OUT_32 = 2'd2
    } out_mode_t;

    // The reserved encoding 3 behaves exactly like the 32-bit mode.
    function automatic out_mode_t decode_mode(input logic [1:0] raw);
        out_mode_t m;
        case (raw)
            2'd0:    m = OUT_8;
            2'd1:    m = OUT_16;
            default: m = OUT_32;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] out_bytes(input out_mode_t mode);
        logic [2:0] n;
        case (mode)
            OUT_8:   n = 3'd1;
            OUT_16:  n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/axis_out_packer_if.sv
// Bundles the result-beat input stream and the byte-packed AXI-Stream output
// of axis_out_packer; 'slave' is the packer's view, 'master' the surroundings'.
interface axis_out_packer_if #(
    parameter int ROWS         = 8,
    parameter int Y_BITS       = 24,
    parameter int M_DATA_WIDTH = 64,
    parameter int W_BPT        = 8
);
    localparam int M_BYTES = M_DATA_WIDTH / 8;

    // Both channels: a beat transfers on a rising clock edge where valid and
    // ready are both high; once valid is raised the payload is held unchanged
    // until that edge, and valid never waits on ready.
    logic                     s_valid;
    logic                     s_ready;
    logic [ROWS*Y_BITS-1:0]   s_data;
    logic                     s_last;
    logic [1:0]               s_mode;

    logic                     m_valid;
    logic                     m_ready;
    logic [M_DATA_WIDTH-1:0]  m_data;
    logic [M_BYTES-1:0]       m_keep;
    logic                     m_last;
    logic [W_BPT-1:0]         m_bytes_per_transfer;

    modport slave (
        input  s_valid, s_data, s_last, s_mode, m_ready,
        output s_ready, m_valid, m_data, m_keep, m_last, m_bytes_per_transfer
    );

    modport master (
        output s_valid, s_data, s_last, s_mode, m_ready,
        input  s_ready, m_valid, m_data, m_keep, m_last, m_bytes_per_transfer
    );

endinterface

// File: rtl/axis_out_packer_elem_fmt.sv
// Formats one signed result element to 8/16/32 bits. Narrowing clamps when
// OUT_SATURATE_EN is defined and plainly truncates otherwise.
module out_elem_fmt
    import out_pkg::*;
#(
    parameter int Y_BITS = 24
) (
    input  logic [Y_BITS-1:0] elem_i,
    input  out_mode_t         mode_i,
    output logic [31:0]       res_o
);

    logic signed [Y_BITS-1:0] elem_s;
    logic signed [31:0]       sext;
    logic [31:0]              narrowed;
    logic [31:0]              ow_mask;

    assign elem_s = elem_i;
    assign sext   = 32'(elem_s);

    always_comb begin
        ow_mask = 32'hFFFF_FFFF;
        case (mode_i)
            OUT_8:   ow_mask = 32'h0000_00FF;
            OUT_16:  ow_mask = 32'h0000_FFFF;
            default: ow_mask = 32'hFFFF_FFFF;
        endcase
    end

`ifdef OUT_SATURATE_EN
    // Clamping only matters when the target width is narrower than the input.
    always_comb begin
        narrowed = sext;
        case (mode_i)
            OUT_8: begin
                if (Y_BITS > 8) begin
                    if (sext > 32'sd127)
                        narrowed = 32'h0000_007F;
                    else if (sext < -32'sd128)
                        narrowed = 32'hFFFF_FF80;
                end
            end
            OUT_16: begin
                if (Y_BITS > 16) begin
                    if (sext > 32'sd32767)
                        narrowed = 32'h0000_7FFF;
                    else if (sext < -32'sd32768)
                        narrowed = 32'hFFFF_8000;
                end
            end
            default: narrowed = sext;
        endcase
    end
`else
    assign narrowed = sext;
`endif

    assign res_o = narrowed & ow_mask;

endmodule

// File: rtl/axis_out_packer.sv
// Packs formatted result elements little-endian into M_DATA_WIDTH AXI-Stream
// beats with partial-beat flush on packet end. Narrowing mode: OUT_SATURATE_EN.
module axis_out_packer
    import out_pkg::*;
#(
    parameter int ROWS         = 8,
    parameter int Y_BITS       = 24,
    parameter int M_DATA_WIDTH = 64,
    parameter int W_BPT        = 8
) (
    input  logic                 aclk,
    input  logic                 areset,
    axis_out_packer_if.slave     bus
);

    localparam int M_BYTES      = M_DATA_WIDTH / 8;
    localparam int IN_MAX_BYTES = ROWS * 4;
    localparam int BUF_BYTES    = IN_MAX_BYTES + M_BYTES;
    localparam int BUF_W        = BUF_BYTES * 8;
    localparam int IN_W         = IN_MAX_BYTES * 8;
    localparam int CW           = $clog2(BUF_BYTES + 1);

    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_pend_q, last_pend_d;
    logic             pkt_active_q, pkt_active_d;
    out_mode_t        mode_q, mode_d;

    out_mode_t        beat_mode;
    logic [31:0]      fmt_res [ROWS];
    logic [IN_W-1:0]  in_bytes;
    logic [CW-1:0]    ib;

    logic             s_ready;
    logic             push;
    logic             m_valid;
    logic             m_last;
    logic             pop;
    logic [CW-1:0]    nb;
    logic [M_BYTES-1:0] keep;

    logic [BUF_W-1:0] shifted;
    logic [CW-1:0]    cnt_after;

    // The first beat of a packet uses the live mode; later beats the latched one.
    assign beat_mode = pkt_active_q ? mode_q : decode_mode(bus.s_mode);

    for (genvar r = 0; r < ROWS; r++) begin : g_fmt
        out_elem_fmt #(
            .Y_BITS (Y_BITS)
        ) u_fmt (
            .elem_i (bus.s_data[r*Y_BITS +: Y_BITS]),
            .mode_i (beat_mode),
            .res_o  (fmt_res[r])
        );
    end

    always_comb begin
        in_bytes = '0;
        for (int r = 0; r < ROWS; r++) begin
            case (beat_mode)
                OUT_8:   in_bytes[r*8  +: 8]  = fmt_res[r][7:0];
                OUT_16:  in_bytes[r*16 +: 16] = fmt_res[r][15:0];
                default: in_bytes[r*32 +: 32] = fmt_res[r];
            endcase
        end
    end

    always_comb begin
        ib = CW'(ROWS * 4);
        case (out_bytes(beat_mode))
            3'd1:    ib = CW'(ROWS);
            3'd2:    ib = CW'(ROWS * 2);
            default: ib = CW'(ROWS * 4);
        endcase
    end

    // Ready reserves room for the widest possible beat, so it never depends
    // on the incoming mode.
    assign s_ready = !areset && !last_pend_q && (cnt_q <= CW'(BUF_BYTES - IN_MAX_BYTES));
    assign push    = bus.s_valid && s_ready;

    assign m_valid = (cnt_q >= CW'(M_BYTES)) || (last_pend_q && (cnt_q != '0));
    assign nb      = (cnt_q < CW'(M_BYTES)) ? cnt_q : CW'(M_BYTES);
    assign m_last  = m_valid && last_pend_q && (cnt_q <= CW'(M_BYTES));
    assign pop     = m_valid && bus.m_ready;

    always_comb begin
        keep = '0;
        for (int b = 0; b < M_BYTES; b++)
            keep[b] = m_valid && (CW'(b) < nb);
    end

    // Bytes at and above cnt_q are kept zero, so the tail of a flushed beat
    // reads as zero and new bytes can simply be OR-ed in.
    always_comb begin
        shifted      = buf_q;
        cnt_after    = cnt_q;
        if (pop) begin
            shifted   = buf_q >> M_DATA_WIDTH;
            cnt_after = cnt_q - nb;
        end

        buf_d        = shifted;
        cnt_d        = cnt_after;
        last_pend_d  = last_pend_q;
        pkt_active_d = pkt_active_q;
        mode_d       = mode_q;

        if (push) begin
            buf_d        = shifted | (BUF_W'(in_bytes) << {cnt_after, 3'b000});
            cnt_d        = cnt_after + ib;
            pkt_active_d = 1'b1;
            if (!pkt_active_q)
                mode_d = beat_mode;
            if (bus.s_last)
                last_pend_d = 1'b1;
        end

        if (pop && m_last) begin
            last_pend_d  = 1'b0;
            pkt_active_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            buf_q        <= '0;
            cnt_q        <= '0;
            last_pend_q  <= 1'b0;
            pkt_active_q <= 1'b0;
            mode_q       <= OUT_8;
        end else begin
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            last_pend_q  <= last_pend_d;
            pkt_active_q <= pkt_active_d;
            mode_q       <= mode_d;
        end
    end

    assign bus.s_ready              = s_ready;
    assign bus.m_valid              = m_valid;
    assign bus.m_data               = buf_q[M_DATA_WIDTH-1:0];
    assign bus.m_keep               = keep;
    assign bus.m_last               = m_last;
    assign bus.m_bytes_per_transfer = m_valid ? W_BPT'(nb) : '0;

endmodule

// File: doc/axis_out_packer.md
# axis_out_packer

Parametrised output packer placed between `proc_engine_out` and the AXI-Stream output port, replacing the fixed sign-pad plus width-adapter path. It accepts one ROWS×Y_BITS result beat per handshake and formats each element to a runtime-selected width of 8, 16 or 32 bits. It packs the formatted bytes little-endian into M_DATA_WIDTH output beats and flushes a partial final beat on packet end, with correct tkeep, tlast and bytes-per-transfer.

## Interface
- ROWS, 8, elements per input beat
- Y_BITS, 24, signed input element width; must be ≤32
- M_DATA_WIDTH, 64, output data width; must be a multiple of 8
- W_BPT, 8, width of bytes-per-transfer output; must satisfy 2^W_BPT > M_DATA_WIDTH/8
- Derived: M_BYTES = M_DATA_WIDTH/8, IN_MAX_BYTES = ROWS*4, BUF_BYTES = IN_MAX_BYTES + M_BYTES
- aclk  in  1  clock
- areset  in  1  reset, synchronous, active-high
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_data  in  ROWS*Y_BITS  element r at bits [r*Y_BITS +: Y_BITS]
- s_last  in  1  last beat of packet
- s_mode  in  2  element width: 0 = 8 bit, 1 = 16 bit, 2 = 32 bit; 3 is reserved and treated as 2
- m_valid  out  1  output beat valid
- m_ready  in  1  output accepted when m_valid && m_ready
- m_data  out  M_DATA_WIDTH  packed bytes, byte 0 at bits [7:0]
- m_keep  out  M_BYTES  byte enables, always contiguous from bit 0
- m_last  out  1  final beat of packet
- m_bytes_per_transfer  out  W_BPT  number of set bits in m_keep

## Operation
- Mode latch: s_mode is captured into mode_q on the first accepted beat of a packet, i.e. when pkt_active is 0. It is held until the tlast beat leaves. s_mode is ignored at all other times.
- Element formatting uses OW = 8<<mode_q bits.
  - If OW ≥ Y_BITS, the element is sign-extended.
  - Otherwise it is narrowed as described under Configuration.
- Each accepted beat therefore contributes IB = ROWS*OW/8 bytes.
- Byte queue: register buf[BUF_BYTES*8] and counter cnt holding 0..BUF_BYTES valid bytes.
  - Push: formatted bytes are written at byte offset cnt (after the pop shift, if a pop occurs in the same cycle).
  - Pop: buf shifts right by M_BYTES bytes.
  - Update rule: cnt_next = cnt + (push ? IB : 0) − (pop ? popped bytes : 0).
- Flush state: `last_pend` is set when a beat with s_last is accepted. It clears when the beat carrying m_last is popped; pkt_active clears at the same time.
- s_ready = !last_pend && cnt ≤ BUF_BYTES − IN_MAX_BYTES. It is computed from registers only.
- m_valid = cnt ≥ M_BYTES || (last_pend && cnt ≠ 0).
- Beat content:
  - m_data = buf[M_DATA_WIDTH-1:0].
  - Popped bytes nb = min(cnt, M_BYTES).
  - m_keep = (1<<nb) − 1.
  - m_bytes_per_transfer = nb.
  - m_last = last_pend && cnt ≤ M_BYTES.
- Empty packet: a single tlast beat still carries ROWS elements, so no zero-length output occurs.

## Timing
- Reset values: s_ready 1 once out of reset (0 while areset is high), m_valid 0, m_last 0, m_keep 0, m_bytes_per_transfer 0, m_data 0. cnt, last_pend, pkt_active and mode_q are all 0.
- Reset mid-packet discards the buffered bytes and the pending last with no output. The first beat after reset starts a new packet.
- Latency: from the accepting s handshake to m_valid is 1 cycle when that beat completes M_BYTES, or when it carries s_last.
- Simultaneous push and pop in one cycle is legal. Throughput is one input and one output per cycle whenever IB ≤ M_BYTES.
- m_data, m_keep, m_last and m_bytes_per_transfer are stable while m_valid && !m_ready.
- Between packets: the first beat of the next packet is accepted in the cycle after the m_last handshake, so there is one bubble.

## Configuration
- `OUT_SATURATE_EN` defined: when OW < Y_BITS, the element is clamped to [−2^(OW−1), 2^(OW−1)−1].
- Not defined: when OW < Y_BITS, the element is truncated to its low OW bits, with no comparators instantiated.
- The macro has no effect for OW ≥ Y_BITS.

## Structure
- Package `out_pkg` holds:
  - the `out_mode_t` enum (OUT_8, OUT_16, OUT_32);
  - the function `out_bytes(mode)` returning 1/2/4.
- Sub-module `out_elem_fmt` contains the per-element sign-extend / saturate / truncate logic, with a 32-bit output. It is instantiated ROWS times; the packer selects the low OW bits of each result.

## Test plan
- ROWS=8, M_DATA_WIDTH=64, mode 0, 3 beats of elements 1..24 with the last on beat 3 → 3 beats of 8 bytes each, keep 0xFF, bpt 8, m_last only on beat 3.
- Mode 2, Y_BITS=24, element −5 (0xFFFFFB) in a single last beat → 4 beats, first bytes FB FF FF FF, m_last on beat 4.
- Mode 1, 1 beat with last, M_DATA_WIDTH=48 → beats of 6/6/4 bytes; final keep 0x0F, bpt 4, m_last on the final beat.
- Element 300 in mode 0: with `OUT_SATURATE_EN` the output byte is 0x7F; without it the output byte is 0x2C.
- Random m_ready backpressure over 100 packets with s_mode toggled mid-packet → the byte stream matches a model that uses the first-beat mode, and outputs stay stable while stalled.
- areset asserted with cnt=12 and last_pend=0 → next cycle m_valid=0 and s_ready=1, and the following packet is output clean.
